// File: rtl/hrm_pkg.sv
// Shared HRM CPU definitions.
// Common data word width and type for REG, inbox, outbox and ALU.
package hrm_pkg;

   localparam int DATA_W = 8;

   typedef logic signed [DATA_W-1:0] hrm_word_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/outbox_mem.sv
// Outbox storage: DEPTH x WIDTH array.
// Synchronous write port, asynchronous read port, no reset.
module outbox_mem
   import hrm_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 8,
   localparam int PW = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/outbox.sv
// HRM CPU output queue: first-word fall-through FIFO
// drained by an external sink over valid/ready.
module outbox
   import hrm_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] iR,
   input  logic             wO,
   input  logic             clr,
   output logic             oFull,
   output logic             oEmpty,
   output logic [CW-1:0]    oCount,
   output logic [WIDTH-1:0] oData,
   output logic             oValid,
   input  logic             iReady,
   output logic             oOvf
);

   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0]    rptr;
   logic [PW-1:0]    wptr;
   logic [CW-1:0]    count;
   logic             ovf;
   logic [WIDTH-1:0] rd_data;
   logic             push;
   logic             pop;

   assign oFull  = (count == CW'(DEPTH));
   assign oEmpty = (count == '0);
   assign oValid = !oEmpty;
   assign oCount = count;
   assign oOvf   = ovf;
   assign oData  = oEmpty ? '0 : rd_data;

   // Full/empty come from the pre-edge count, so a pop never admits a push.
   assign push = wO && !oFull && !clr;
   assign pop  = oValid && iReady && !clr;

   outbox_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wptr),
      .wdata (iR),
      .raddr (rptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (wO && oFull) ovf <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && pop) $display("OUTBOX %02h", oData);
   end
`endif

`ifdef FORMAL
   a_cnt_max: assert property (@(posedge clk)
      oCount <= CW'(DEPTH));
   a_valid: assert property (@(posedge clk)
      oValid == !oEmpty);
   a_data_known: assert property (@(posedge clk)
      !$isunknown(^oData));
   a_ptr_cnt: assert property (@(posedge clk)
      disable iff (!rst_n)
      PW'(wptr - rptr) == count[PW-1:0]);
`endif

endmodule

// File: doc/outbox.md
Name: outbox

Overview:
- Output queue of the HRM CPU; the consumer-side counterpart of the inbox.
- The CPU's OUTBOX instruction pushes the current register value R into the queue.
- An external sink (UART, testbench or display) drains the queue over a valid/ready handshake.
- `oFull` is fed back to the control unit so it can stall an OUTBOX instruction until space frees up.

Parameters:
- WIDTH, 8, data word width; must equal the width of R.
- DEPTH, 8, number of entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iR  input  WIDTH  value of register R to enqueue.
- wO  input  1  push strobe from the control unit (OUTBOX instruction).
- clr  input  1  synchronous flush, active-high.
- oFull  output  1  queue holds DEPTH entries.
- oEmpty  output  1  queue holds 0 entries.
- oCount  output  CW  current occupancy, 0..DEPTH.
- oData  output  WIDTH  head-of-queue word.
- oValid  output  1  oData is valid; equals !oEmpty.
- iReady  input  1  sink accepts the head word this cycle.
- oOvf  output  1  sticky error flag: a push was attempted while full.

Behaviour:
- Reset:
  - rst_n low asynchronously clears the read pointer, write pointer, oCount and oOvf.
  - While reset is held: oFull=0, oEmpty=1, oValid=0, oData=0.
  - Storage array is not reset.
  - Reset asserted mid-transfer discards all queued words; nothing is emitted afterwards.
- Push:
  - A push happens on a rising edge where wO=1 and oFull=0.
  - iR is written at wptr, and wptr increments modulo DEPTH (natural wrap).
- Pop:
  - A pop happens on a rising edge where oValid=1 and iReady=1.
  - rptr increments modulo DEPTH.
- Output timing:
  - First-word fall-through: oData is combinational from mem[rptr] while the queue is not empty, and is forced to 0 when empty, so the output is never X.
  - Push-to-oValid latency is 1 cycle: a word pushed at edge N is visible after edge N.
- Count:
  - oCount +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
  - oFull = (oCount==DEPTH); oEmpty = (oCount==0). Both are derived from the count, never from pointer equality.
- Boundary cases:
  - Full: a push attempt is dropped, storage is unchanged and oOvf is set. The full check uses the pre-edge state, so a simultaneous pop does not admit the push; the control unit must stall instead.
  - Empty with wO=1 and iReady=1: only the push takes effect; the pop is impossible because oValid=0.
  - Push and pop in the same cycle while not empty and not full: both take effect and oCount is unchanged.
  - Pointer wrap from DEPTH-1 to 0 needs no special handling.
- clr:
  - Takes priority over push and pop in the same cycle.
  - Clears both pointers, oCount and oOvf.
  - Any push or pop in that cycle is ignored.
- iReady while oValid=0 has no effect.
- oData stays stable while oValid=1 and iReady=0. The sink may hold off indefinitely.
- Non-synthesis build: a `$display` of the word is emitted on each pop, tagged "OUTBOX".
- Formal build:
  - Assert oCount<=DEPTH.
  - Assert oValid==!oEmpty.
  - Assert no X/Z in oData (reduction-XOR check).
  - Assert oCount is consistent with the pointers: (wptr-rptr) mod DEPTH == oCount mod DEPTH.

Decomposition:
- Shared package `hrm_pkg`: `DATA_W=8` and the `hrm_word_t` typedef (signed [7:0]), used by REG, inbox, outbox and ALU.
- Optional sub-module `outbox_mem`: DEPTH x WIDTH storage with a synchronous write port and an asynchronous read port. Pointer, count and flag logic stay in `outbox`.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then release, no stimulus -> oEmpty=1, oValid=0, oCount=0, oData=0, oOvf=0.
- Single word: push iR=8'h2A with iReady=0 -> next cycle oValid=1, oData=2A, oCount=1; raise iReady -> after the edge oEmpty=1.
- Fill and overflow (DEPTH=8): push 8'h01..8'h08 -> oFull=1, oCount=8. Push 8'hFF -> oOvf=1, oCount still 8. Drain -> output sequence 01..08, 8'hFF never appears.
- Wrap and backpressure:
  - Push 5, pop 5, then push 6 words (crosses the pointer wrap) -> FIFO order preserved.
  - Toggle iReady pseudo-randomly -> oData stable whenever iReady=0.
- Simultaneous push and pop at count 3 -> count stays 3; head advances; new word appears last.
- Mid-operation disturbances:
  - clr with wO=1 at count 4 -> count 0, oOvf=0, pushed word discarded.
  - rst_n pulsed low asynchronously between edges at count 5 -> immediate oValid=0 and oCount=0.
